dh_dwxh_rec: RTL and testbench
==============================

# dh_dwxh_rec

Sequential GRU sensitivity-recurrence engine for the dh/dW_xh gradient path, parametrised in hidden width and fixed-point format. Each step computes d_t[i] = Σ_j J[i][j]·d_{t-1}[j] + (i==n ? a_t : 0), where J is the per-step Jacobian dh_t/dh_{t-1} and a_t is the scalar input-injection term for target lane n. The block holds d_{t-1} internally across steps. It sits between the Jacobian/injection stages and the gradient accumulator, with valid/ready on both sides.

## Interface
- DATABIT, 16, signed data width of every lane, J entry and a_t
- FRAC, 12, fractional bits (Q(DATABIT-FRAC).FRAC)
- HNUM, 4, hidden lanes (≥2)
- NW, max(1,$clog2(HNUM)), width of lane index n
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  step request
- in_ready  out  1  block can accept a step
- seq_start  in  1  sampled with step; treat d_{t-1} as all-zero
- n  in  NW  injection lane
- a_t  in  DATABIT  signed injection value
- jac  in  HNUM*HNUM*DATABIT  J[i][j] at [(i*HNUM+j)*DATABIT +: DATABIT]
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  HNUM*DATABIT  lane i at [i*DATABIT +: DATABIT]
- sat  out  1  at least one lane saturated in this result

## Operation
- FSM states: IDLE → MAC → FIN → OUT → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: capture jac, n, a_t and seq_start.
  - Clear the HNUM accumulators (ACCBIT = 2*DATABIT+$clog2(HNUM)+1 bits each).
  - Column counter j=0. Go to MAC.
- MAC:
  - One column per cycle, HNUM multipliers: acc[i] += J[i][j]·dprev[j].
  - dprev[j] is forced to 0 when the captured seq_start=1.
  - j counts 0..HNUM-1, then go to FIN.
- FIN, per lane:
  - Add (a_t <<< FRAC) to lane n only.
  - Round half-up: add 1<<(FRAC-1), then arithmetic shift right by FRAC.
  - Saturate to [-2^(DATABIT-1), 2^(DATABIT-1)-1].
  - Register result and sat; write the saturated values into the dprev state. Go to OUT.
- n ≥ HNUM (non-power-of-2 HNUM): no injection on any lane; the step otherwise proceeds normally.
- OUT:
  - out_valid=1. result and sat hold stable.
  - Go to IDLE on out_ready.
- in_ready=0 in MAC, FIN and OUT. in_valid outside IDLE is ignored and not queued.

## Timing
- Acceptance at edge k (IDLE, in_valid=1).
- MAC occupies edges k+1..k+HNUM, FIN is edge k+HNUM+1, and out_valid is high from k+HNUM+1.
- Latency is HNUM+1 cycles.
- in_ready returns the cycle after the out_valid&out_ready handshake.
- Throughput: one step per HNUM+3 cycles with out_ready held high.
- Reset values: in_ready=1 after reset, out_valid=0, result=0, sat=0, dprev=0, FSM=IDLE, j=0.
- Reset asserted mid-MAC/FIN/OUT: the step is discarded and dprev is cleared, so the next step behaves as if seq_start=1.
- dprev updates only in FIN. A step with seq_start=1 overwrites all lanes.

## Structure
- Shared package holds:
  - the FSM state encoding (IDLE, MAC, FIN, OUT);
  - the ACCBIT formula;
  - round/saturate helper functions parametrised by DATABIT/FRAC.
- One sub-module, dh_rec_lane: one lane's MAC accumulator plus round/saturate, instantiated HNUM times.
- The FSM, column counter, jac/dprev registers and handshake live at top level.

## Test plan
All scenarios use DATABIT=16, FRAC=12, HNUM=4; 1.0 = 4096.
1. Reset and idle:
   - Stimulus: assert rst for 3 cycles, release.
   - Response: in_ready=1; out_valid=0, result=0, sat=0 throughout.
2. Identity step with injection:
   - Stimulus: seq_start=1, J=identity (diagonal 4096), a_t=4096, n=2.
   - Response: out_valid on the 5th edge after acceptance; lanes {0,0,4096,0}; sat=0.
3. Recurrence:
   - Stimulus: after test 2, seq_start=0, diagonal 2048, a_t=0.
   - Response: lanes {0,0,2048,0}.
   - Follow-up: J[0][2]=-4096, J[3][2]=1, a_t=0.
   - Response: lane0=-2048; lane3 = round(2048·1/4096) = 1 (half-up from 0.5).
4. Saturation:
   - Stimulus: seq_start=1, J=0, a_t=16384, n=0. Then J[0][0]=16384, a_t=0.
   - Response: lane0=32767, sat=1.
   - Stimulus: repeat with J[0][0]=-16384.
   - Response: lane0=-32768, sat=1.
5. Backpressure:
   - Stimulus: hold out_ready=0 for 6 cycles while pulsing in_valid.
   - Response: result stable; in_ready=0; no extra step accepted.
   - Stimulus: raise out_ready.
   - Response: one handshake; in_ready=1 the next cycle.
6. Reset mid-MAC:
   - Stimulus: pulse rst at edge k+2 of a step, then send a step with seq_start=0, J=identity, a_t=0.
   - Response: lanes all 0 (dprev was cleared); no out_valid from the aborted step.

Source files
------------

// File: rtl/dh_dwxh_rec_pkg.sv
// dh_dwxh_rec_pkg
// Shared definitions for the dh/dW_xh sensitivity-recurrence engine:
//   - state_t       : FSM state encoding (IDLE, MAC, FIN, OUT)
//   - acc_bits()    : accumulator width for a given data width / lane count
//   - round_half_up : add half an LSB, then arithmetic shift right by frac
//   - sat_value     : clamp to the signed databit-wide range
//   - is_sat        : flag when clamping changes the value
// The helpers work on a 64-bit signed carrier so a single definition serves
// every DATABIT/FRAC combination; callers narrow the result themselves.
package dh_dwxh_rec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_FIN  = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Full-precision product sum of hnum terms plus one guard bit for injection.
  function automatic int acc_bits(input int databit, input int hnum);
    return 2 * databit + $clog2(hnum) + 1;
  endfunction

  function automatic logic signed [63:0] round_half_up(input logic signed [63:0] v,
                                                       input int frac);
    logic signed [63:0] half;
    half = 64'sd1 <<< (frac - 1);
    return (v + half) >>> frac;
  endfunction

  function automatic logic signed [63:0] sat_hi(input int databit);
    return (64'sd1 <<< (databit - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int databit);
    return -(64'sd1 <<< (databit - 1));
  endfunction

  function automatic logic signed [63:0] sat_value(input logic signed [63:0] v,
                                                   input int databit);
    if (v > sat_hi(databit)) return sat_hi(databit);
    if (v < sat_lo(databit)) return sat_lo(databit);
    return v;
  endfunction

  function automatic logic is_sat(input logic signed [63:0] v, input int databit);
    return (v > sat_hi(databit)) || (v < sat_lo(databit));
  endfunction

endpackage

// File: rtl/dh_rec_lane.sv
// dh_rec_lane
// One output lane of the recurrence: a multiply-accumulate register fed one
// (J[i][j], dprev[j]) pair per MAC cycle, followed by combinational
// injection, half-up rounding and saturation of the accumulated sum.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr_i      : clear the accumulator (step acceptance)
//   mac_en_i   : accumulate coef_i * dprev_i this cycle
//   coef_i     : J[i][j] for the current column
//   dprev_i    : d_{t-1}[j] for the current column (already gated by seq_start)
//   inj_en_i   : this lane is the injection target
//   a_t_i      : injection value (same Q format as the data)
//   res_o      : rounded, saturated lane value (valid once MAC is done)
//   sat_o      : res_o was clamped
module dh_rec_lane
  import dh_dwxh_rec_pkg::*;
#(
  parameter int DATABIT = 16,
  parameter int FRAC    = 12,
  parameter int HNUM    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      mac_en_i,
  input  logic signed [DATABIT-1:0] coef_i,
  input  logic signed [DATABIT-1:0] dprev_i,
  input  logic                      inj_en_i,
  input  logic signed [DATABIT-1:0] a_t_i,
  output logic signed [DATABIT-1:0] res_o,
  output logic                      sat_o
);

  localparam int ACCBIT = acc_bits(DATABIT, HNUM);

  logic signed [ACCBIT-1:0]    acc_q, acc_d;
  logic signed [2*DATABIT-1:0] prod;
  logic signed [63:0]          pre_w, rnd_w;

  assign prod = coef_i * dprev_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (mac_en_i) begin
      acc_d = acc_q + ACCBIT'(prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  // The product sum carries 2*FRAC fractional bits, so the injection term is
  // aligned by FRAC before the single rounding shift.
  always_comb begin
    pre_w = 64'(acc_q);
    if (inj_en_i) pre_w = pre_w + (64'(a_t_i) <<< FRAC);
    rnd_w = round_half_up(pre_w, FRAC);
    res_o = DATABIT'(sat_value(rnd_w, DATABIT));
    sat_o = is_sat(rnd_w, DATABIT);
  end

endmodule

// File: rtl/dh_dwxh_rec.sv
// dh_dwxh_rec
// Sequential GRU sensitivity recurrence: d_t = J * d_{t-1} + a_t * e_n.
// One Jacobian column is consumed per MAC cycle across HNUM lanes; the
// rounded and saturated result becomes the next step's d_{t-1}.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : step request handshake
//   seq_start            : start of sequence, treat d_{t-1} as zero
//   n, a_t               : injection lane and value
//   jac                  : J[i][j] at [(i*HNUM+j)*DATABIT +: DATABIT]
//   out_valid / out_ready: result handshake
//   result               : lane i at [i*DATABIT +: DATABIT]
//   sat                  : some lane of result was clamped
module dh_dwxh_rec
  import dh_dwxh_rec_pkg::*;
#(
  parameter int DATABIT = 16,
  parameter int FRAC    = 12,
  parameter int HNUM    = 4,
  parameter int NW      = (HNUM > 1) ? $clog2(HNUM) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           seq_start,
  input  logic [NW-1:0]                  n,
  input  logic [DATABIT-1:0]             a_t,
  input  logic [HNUM*HNUM*DATABIT-1:0]   jac,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [HNUM*DATABIT-1:0]        result,
  output logic                           sat
);

  state_t                    state_q;
  logic [NW-1:0]             j_q;
  logic signed [DATABIT-1:0] jac_q   [HNUM][HNUM];
  // dprev doubles as the result register: both are written with the same
  // saturated values in FIN and both clear on reset.
  logic signed [DATABIT-1:0] dprev_q [HNUM];
  logic [NW-1:0]             n_q;
  logic signed [DATABIT-1:0] a_t_q;
  logic                      seq_q;
  logic                      in_ready_q;
  logic                      out_valid_q;
  logic                      sat_q;

  logic                      acc_clr;
  logic                      mac_en;
  logic signed [DATABIT-1:0] col_dprev;
  logic signed [DATABIT-1:0] lane_res [HNUM];
  logic [HNUM-1:0]           lane_sat;

  assign acc_clr   = (state_q == ST_IDLE) && in_valid;
  assign mac_en    = (state_q == ST_MAC);
  assign col_dprev = seq_q ? '0 : dprev_q[j_q];

  generate
    for (genvar gi = 0; gi < HNUM; gi++) begin : g_lane
      dh_rec_lane #(
        .DATABIT (DATABIT),
        .FRAC    (FRAC),
        .HNUM    (HNUM)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (acc_clr),
        .mac_en_i (mac_en),
        .coef_i   (jac_q[gi][j_q]),
        .dprev_i  (col_dprev),
        .inj_en_i (n_q == NW'(gi)),
        .a_t_i    (a_t_q),
        .res_o    (lane_res[gi]),
        .sat_o    (lane_sat[gi])
      );
      assign result[gi*DATABIT +: DATABIT] = dprev_q[gi];
    end
  endgenerate

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sat       = sat_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      j_q         <= '0;
      n_q         <= '0;
      a_t_q       <= '0;
      seq_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      for (int i = 0; i < HNUM; i++) begin
        dprev_q[i] <= '0;
        for (int j = 0; j < HNUM; j++) jac_q[i][j] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < HNUM; i++)
              for (int j = 0; j < HNUM; j++)
                jac_q[i][j] <= jac[(i*HNUM+j)*DATABIT +: DATABIT];
            n_q        <= n;
            a_t_q      <= a_t;
            seq_q      <= seq_start;
            j_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (j_q == NW'(HNUM - 1)) begin
            j_q     <= '0;
            state_q <= ST_FIN;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        ST_FIN: begin
          for (int i = 0; i < HNUM; i++) dprev_q[i] <= lane_res[i];
          sat_q       <= |lane_sat;
          out_valid_q <= 1'b1;
          state_q     <= ST_OUT;
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dh_dwxh_rec.sv
// tb_dh_dwxh_rec
// Directed bench for dh_dwxh_rec (DATABIT=16, FRAC=12, HNUM=4). A timeline
// model computes each step's result with plain integer arithmetic and tracks
// when in_ready/out_valid must be high; a compare process checks every cycle.
// Directed steps additionally pin hand-computed lane values.
module tb_dh_dwxh_rec;

  localparam int DB = 16;
  localparam int FR = 12;
  localparam int HN = 4;
  localparam int NWB = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 seq_start;
  logic [NWB-1:0]       n;
  logic [DB-1:0]        a_t;
  logic [HN*HN*DB-1:0]  jac;
  logic                 out_valid;
  logic                 out_ready;
  logic [HN*DB-1:0]     result;
  logic                 sat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dh_dwxh_rec #(
    .DATABIT (DB),
    .FRAC    (FR),
    .HNUM    (HN),
    .NW      (NWB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .seq_start (seq_start),
    .n         (n),
    .a_t       (a_t),
    .jac       (jac),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .sat       (sat)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  longint m_d   [HN];   // d_{t-1} as the model sees it
  longint m_p   [HN];   // pending result of the step in flight
  longint m_res [HN];   // result visible on the outputs
  bit     m_psat, m_sat, m_ov, m_ir;
  int     m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < HN; i++) begin m_d[i] = 0; m_res[i] = 0; end
      m_sat = 0; m_ov = 0; m_ir = 1; m_cnt = 0;
    end else if (m_ir && in_valid) begin
      m_psat = 0;
      for (int i = 0; i < HN; i++) begin
        longint s, r, dj, jij;
        s = 0;
        for (int j = 0; j < HN; j++) begin
          jij = longint'($signed(jac[(i*HN+j)*DB +: DB]));
          dj  = seq_start ? 0 : m_d[j];
          s  += jij * dj;
        end
        if (i == int'(n)) s += longint'($signed(a_t)) * 4096;
        r = (s + 2048) >>> 12;
        if (r > 32767)  begin r = 32767;  m_psat = 1; end
        if (r < -32768) begin r = -32768; m_psat = 1; end
        m_p[i] = r;
      end
      m_ir  = 0;
      m_cnt = HN + 1;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        for (int i = 0; i < HN; i++) begin m_d[i] = m_p[i]; m_res[i] = m_p[i]; end
        m_sat = m_psat;
        m_ov  = 1;
      end
    end else if (m_ov && out_ready) begin
      m_ov = 0;
      m_ir = 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [63:0] exp_res;
    exp_res = '0;
    for (int i = 0; i < HN; i++) exp_res[i*DB +: DB] = m_res[i][DB-1:0];
    check("in_ready",  64'(in_ready),  64'(m_ir));
    check("out_valid", 64'(out_valid), 64'(m_ov));
    check("result",    64'(result),    exp_res);
    check("sat",       64'(sat),       64'(m_sat));
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_j();
    jac = '0;
  endtask

  task automatic set_j(input int i, input int j, input int v);
    jac[(i*HN+j)*DB +: DB] = DB'(v);
  endtask

  task automatic diag(input int v);
    clear_j();
    for (int i = 0; i < HN; i++) set_j(i, i, v);
  endtask

  task automatic do_step(input string name, input bit ss, input int nn, input int aa,
                         input bit hold, output logic [63:0] got, output logic gsat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #2; w++; end
    if (!in_ready) check({name, "_accept_timeout"}, 64'(in_ready), 64'd1);
    seq_start = ss; n = NWB'(nn); a_t = DB'(aa); out_ready = !hold;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin @(posedge clk); #2; w++; end
    check({name, "_latency"}, 64'(w), 64'd5);
    got  = 64'(result);
    gsat = sat;
    $display("step %s seq=%0d n=%0d a=%0d -> result=%h sat=%0d", name, ss, nn, aa, result, sat);
  endtask

  function automatic logic [63:0] lanes(input int l0, input int l1, input int l2, input int l3);
    logic [63:0] v;
    v = {DB'(l3), DB'(l2), DB'(l1), DB'(l0)};
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] got, held;
    logic        gs;
    rst = 1'b1; in_valid = 1'b0; seq_start = 1'b0; n = '0; a_t = '0; jac = '0;
    out_ready = 1'b1;

    // 1. reset and idle
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("t1_in_ready",  64'(in_ready),  64'd1);
    check("t1_out_valid", 64'(out_valid), 64'd0);
    check("t1_result",    64'(result),    64'd0);
    check("t1_sat",       64'(sat),       64'd0);

    // 2. identity with injection on lane 2
    diag(4096);
    do_step("t2_ident", 1, 2, 4096, 0, got, gs);
    check("t2_lanes", got, lanes(0, 0, 4096, 0));
    check("t2_sat", 64'(gs), 64'd0);

    // 3. recurrence
    diag(2048);
    do_step("t3_half", 0, 2, 0, 0, got, gs);
    check("t3_lanes", got, lanes(0, 0, 2048, 0));
    clear_j(); set_j(0, 2, -4096); set_j(3, 2, 1);
    do_step("t3_cross", 0, 0, 0, 0, got, gs);
    check("t3_cross_lanes", got, lanes(-2048, 0, 0, 1));

    // dense step: model-checked only
    for (int i = 0; i < HN; i++)
      for (int j = 0; j < HN; j++) set_j(i, j, ((i*HN + j) * 977) % 8192 - 4096);
    do_step("dense", 0, 1, -1234, 0, got, gs);

    // 4. saturation both directions
    clear_j();
    do_step("t4_load", 1, 0, 16384, 0, got, gs);
    check("t4_load_lanes", got, lanes(16384, 0, 0, 0));
    set_j(0, 0, 16384);
    do_step("t4_pos", 0, 0, 0, 0, got, gs);
    check("t4_pos_lanes", got, lanes(32767, 0, 0, 0));
    check("t4_pos_sat", 64'(gs), 64'd1);
    clear_j();
    do_step("t4_reload", 1, 0, 16384, 0, got, gs);
    set_j(0, 0, -16384);
    do_step("t4_neg", 0, 0, 0, 0, got, gs);
    check("t4_neg_lanes", got, lanes(-32768, 0, 0, 0));
    check("t4_neg_sat", 64'(gs), 64'd1);

    // 5. backpressure: d = {-32768,0,0,0}, identity, inject 100 on lane 3
    diag(4096);
    do_step("t5_bp", 0, 3, 100, 1, got, gs);
    check("t5_lanes", got, lanes(-32768, 0, 0, 100));
    check("t5_sat", 64'(gs), 64'd0);
    held = got;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c % 2 == 0);
      @(posedge clk); #2;
      check("t5_hold_in_ready",  64'(in_ready),  64'd0);
      check("t5_hold_out_valid", 64'(out_valid), 64'd1);
      check("t5_hold_result",    64'(result),    held);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    check("t5_release_out_valid", 64'(out_valid), 64'd0);
    check("t5_release_in_ready",  64'(in_ready),  64'd1);
    repeat (8) @(posedge clk);
    #2 check("t5_no_extra_step", 64'(out_valid), 64'd0);

    // 6. reset mid-MAC discards the step and clears dprev
    diag(4096);
    seq_start = 1'b0; n = '0; a_t = DB'(1000);
    in_valid = 1'b1;
    @(posedge clk); #2;           // accepted at edge k
    in_valid = 1'b0;
    @(posedge clk); #2;           // edge k+1
    rst = 1'b1;
    @(posedge clk); #2;           // edge k+2 under reset
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #2;
      check("t6_no_out_valid", 64'(out_valid), 64'd0);
    end
    diag(4096);
    do_step("t6_after_rst", 0, 0, 0, 0, got, gs);
    check("t6_lanes", got, lanes(0, 0, 0, 0));

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
